mux_stream_rr: RTL and testbench
================================

// Module: mux_stream_rr
// PURPOSE
//  Parametrised N-channel, W-bit stream multiplexer. It replaces the fixed 16:1 bit mux with a
//  registered, valid/ready-handshaked selector.
//  Two modes: manual (channel chosen by sel) and round-robin (fair scan of valid inputs).
//  Sits between multiple producer streams and a single consumer; one output register stage.
// PARAMETERS
//  N_CH   16              number of input channels (>=2, need not be a power of two)
//  W      8               data width per channel
//  SELW   $clog2(N_CH)    width of sel/out_ch (derived, do not override)
// PORTS
//  clk        in   1         clock, all logic on rising edge
//  rst_n      in   1         synchronous active-low reset
//  in_data    in   N_CH*W    channel c data = in_data[c*W +: W]
//  in_valid   in   N_CH      per-channel valid
//  in_ready   out  N_CH      per-channel ready (at most one bit high)
//  mode       in   1         0 = manual (sel), 1 = round-robin
//  sel        in   SELW      manual channel select
//  out_data   out  W         registered output data
//  out_valid  out  1         output valid
//  out_ready  in   1         consumer ready
//  out_ch     out  SELW      channel index of word in out_data
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): out_valid=0, out_data=0, out_ch=0, rr_ptr=0. Any held word is
//    dropped. in_ready is all-zero while rst_n=0.
//  - load_en = !out_valid | out_ready. The output register accepts a new word only when load_en=1.
//  - Grant (combinational, gnt index + gnt_vld):
//      manual: gnt=sel. gnt_vld=in_valid[sel] when sel<N_CH; gnt_vld=0 when sel>=N_CH.
//      rr: gnt = first c with in_valid[c]=1, scanning rr_ptr, rr_ptr+1, ... mod N_CH.
//          gnt_vld=0 when no valid input.
//  - in_ready[gnt]=load_en. Only this bit may be high; all others are 0. In manual mode with
//    sel>=N_CH, all bits are 0.
//    in_ready does not depend on in_valid of its own channel in manual mode.
//  - Transfer on channel c when in_valid[c] & in_ready[c]. Next edge: out_data<=channel c data,
//    out_ch<=c, out_valid<=1. Latency: 1 clk input->output.
//  - Output handshake: word retired when out_valid & out_ready.
//      If load_en=1 with no transfer, out_valid<=0.
//      Simultaneous retire and transfer: new word loads, out_valid stays 1 (full throughput,
//      1 word/clk).
//  - Backpressure: out_valid=1 & out_ready=0 holds out_data/out_ch stable; all in_ready=0.
//  - rr_ptr updates only on a transfer in rr mode: rr_ptr <= (gnt==N_CH-1) ? 0 : gnt+1.
//    Explicit wrap, valid for any N_CH. Unchanged in manual mode.
//  - A mode/sel change takes effect on the same cycle's grant. It never alters a word already
//    in the output register.
// TESTING
//  1 manual, N_CH=16,W=8: sel=5, ch5=0xA5 valid, out_ready=1 -> next clk out_data=0xA5,
//    out_ch=5, out_valid=1; in_ready=16'h0020.
//  2 backpressure: hold out_ready=0 for 3 clks after a load -> out_data/out_ch stable,
//    in_ready=0; release -> next word loads same edge.
//  3 rr, all 16 valid, out_ready=1 -> out_ch sequence 0,1,...,15,0,1 at 1 word/clk.
//  4 rr, only ch3 and ch12 valid -> out_ch alternates 3,12,3,12; ch12 drop after grant -> 3,3,3.
//  5 N_CH=5: rr all valid -> out_ch 0,1,2,3,4,0. Manual sel=6 -> in_ready=0, out_valid
//    falls after retire.
//  6 rst_n=0 with out_valid=1 and rr_ptr=7 -> next clk out_valid=0, out_data=0, out_ch=0;
//    first rr grant after reset = ch0.

Source files
------------

// File: rtl/mux_stream_rr.sv
// N-channel stream multiplexer with one registered output stage.
// Channel selection is manual (sel) or round-robin over the valid inputs.
module mux_stream_rr #(
    parameter int unsigned N_CH = 16,
    parameter int unsigned W    = 8,
    parameter int unsigned SELW = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH*W-1:0] in_data,
    input  logic [N_CH-1:0]   in_valid,
    output logic [N_CH-1:0]   in_ready,
    input  logic              mode,
    input  logic [SELW-1:0]   sel,
    output logic [W-1:0]      out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SELW-1:0]   out_ch
);

    logic [W-1:0]    ch_data [N_CH];
    logic [W-1:0]    out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d;
    logic [SELW-1:0] out_ch_q, out_ch_d;
    logic [SELW-1:0] rr_ptr_q, rr_ptr_d;

    logic [SELW-1:0] rr_gnt, gnt;
    logic            rr_vld, sel_ok, gnt_ok, gnt_vld, load_en, xfer;
    logic [SELW:0]   cand;

    for (genvar c = 0; c < N_CH; c++) begin : g_unpack
        assign ch_data[c] = in_data[c*W +: W];
    end

    // Scan offsets from far to near so the closest valid channel after rr_ptr wins.
    always_comb begin
        rr_gnt = '0;
        rr_vld = 1'b0;
        cand   = '0;
        for (int unsigned i = N_CH; i > 0; i--) begin
            cand = {1'b0, rr_ptr_q} + (SELW+1)'(i - 1);
            if (cand >= (SELW+1)'(N_CH)) cand = cand - (SELW+1)'(N_CH);
            if (in_valid[cand[SELW-1:0]]) begin
                rr_gnt = cand[SELW-1:0];
                rr_vld = 1'b1;
            end
        end
    end

    always_comb begin
        sel_ok   = ({1'b0, sel} < (SELW+1)'(N_CH));
        gnt      = mode ? rr_gnt : sel;
        gnt_ok   = mode ? rr_vld : sel_ok;
        gnt_vld  = mode ? rr_vld : (sel_ok & in_valid[sel]);
        load_en  = !out_valid_q | out_ready;
        xfer     = gnt_vld & load_en;
        in_ready = '0;
        if (rst_n && gnt_ok) in_ready[gnt] = load_en;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        rr_ptr_d    = rr_ptr_q;
        if (load_en) begin
            out_valid_d = xfer;
            if (xfer) begin
                out_data_d = ch_data[gnt];
                out_ch_d   = gnt;
            end
        end
        if (xfer && mode) rr_ptr_d = (gnt == SELW'(N_CH - 1)) ? '0 : gnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_stream_rr.sv
// Bench for mux_stream_rr: a 16-channel and a 5-channel instance driven side by side
// and compared each cycle against a queue-free arithmetic model of the selection rules.
module tb_mux_stream_rr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, mode, out_ready;
    logic [127:0] data16;
    logic [15:0]  vld16, rdy16;
    logic [3:0]   sel16, ch16;
    logic [7:0]   od16;
    logic         ov16;
    logic [39:0]  data5;
    logic [4:0]   vld5, rdy5;
    logic [2:0]   sel5, ch5;
    logic [7:0]   od5;
    logic         ov5;

    int total = 0;
    int bad   = 0;
    int m_ov[2], m_od[2], m_oc[2], m_ptr[2];

    mux_stream_rr #(.N_CH(16), .W(8)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_data(data16), .in_valid(vld16), .in_ready(rdy16),
        .mode(mode), .sel(sel16), .out_data(od16), .out_valid(ov16), .out_ready(out_ready),
        .out_ch(ch16)
    );

    mux_stream_rr #(.N_CH(5), .W(8)) dut5 (
        .clk(clk), .rst_n(rst_n), .in_data(data5), .in_valid(vld5), .in_ready(rdy5),
        .mode(mode), .sel(sel5), .out_data(od5), .out_valid(ov5), .out_ready(out_ready),
        .out_ch(ch5)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Check one instance against the model for the current cycle, then advance the model.
    task automatic model_step(input int k);
        int n, g, s, c;
        logic [15:0]  v, rdy, er;
        logic [127:0] dat;
        logic [7:0]   od;
        logic [3:0]   oc;
        logic         ov;
        bit           load, xf;
        if (k == 0) begin
            n = 16; v = vld16; dat = data16; s = int'(sel16); rdy = rdy16;
            od = od16; oc = ch16; ov = ov16;
        end else begin
            n = 5; v = {11'b0, vld5}; dat = {88'b0, data5}; s = int'(sel5); rdy = {11'b0, rdy5};
            od = od5; oc = {1'b0, ch5}; ov = ov5;
        end
        load = (m_ov[k] == 0) || out_ready;
        g = -1;
        if (mode) begin
            for (int off = 0; off < n; off++) begin
                c = (m_ptr[k] + off) % n;
                if (g < 0 && v[c]) g = c;
            end
        end else if (s < n) begin
            g = s;
        end
        er = '0;
        if (rst_n && g >= 0 && load) er[g] = 1'b1;
        chk($sformatf("k%0d_in_ready", k), 32'(rdy), 32'(er));
        chk($sformatf("k%0d_out_valid", k), 32'(ov), 32'(m_ov[k]));
        chk($sformatf("k%0d_out_data", k), 32'(od), 32'(m_od[k]));
        chk($sformatf("k%0d_out_ch", k), 32'(oc), 32'(m_oc[k]));
        xf = (g >= 0) && v[g] && load;
        if (!rst_n) begin
            m_ov[k] = 0; m_od[k] = 0; m_oc[k] = 0; m_ptr[k] = 0;
        end else if (load) begin
            if (xf) begin
                m_ov[k] = 1;
                m_od[k] = int'(dat[g*8 +: 8]);
                m_oc[k] = g;
                if (mode) m_ptr[k] = (g + 1) % n;
            end else begin
                m_ov[k] = 0;
            end
        end
    endtask

    task automatic cyc();
        #3;
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
    endtask

    task automatic rnd_data();
        for (int i = 0; i < 16; i++) data16[i*8 +: 8] = 8'($urandom);
        for (int i = 0; i < 5; i++) data5[i*8 +: 8] = 8'($urandom);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_ov[k] = 0; m_od[k] = 0; m_oc[k] = 0; m_ptr[k] = 0;
        end
        rst_n = 1'b0; mode = 1'b0; out_ready = 1'b1;
        sel16 = '0; sel5 = '0; vld16 = '0; vld5 = '0; data16 = '0; data5 = '0;
        @(posedge clk);
        #1;
        cyc();
        rst_n = 1'b1;

        // manual select of channel 5
        sel16 = 4'd5; vld16 = 16'h0020; data16[5*8 +: 8] = 8'hA5;
        sel5 = 3'd2; vld5 = 5'b00100;
        #3;
        chk("t1_in_ready", 32'(rdy16), 32'h0020);
        #(-0);
        @(posedge clk);
        #1;
        chk("t1_out_data", 32'(od16), 32'hA5);
        chk("t1_out_ch", 32'(ch16), 32'd5);
        chk("t1_out_valid", 32'(ov16), 32'd1);
        m_ov[0] = 1; m_od[0] = 32'hA5; m_oc[0] = 5;
        m_ov[1] = 1; m_od[1] = int'(data5[2*8 +: 8]); m_oc[1] = 2;

        // backpressure for three cycles, then release
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rnd_data(); vld16 = 16'($urandom); vld5 = 5'($urandom);
            cyc();
        end
        out_ready = 1'b1;
        rnd_data();
        cyc();

        // round-robin, all valid
        mode = 1'b1; vld16 = '1; vld5 = '1;
        for (int i = 0; i < 18; i++) begin
            rnd_data();
            cyc();
            chk("rr_all_ch16", 32'(ch16), 32'(i % 16));
            chk("rr_all_ch5", 32'(ch5), 32'(i % 5));
        end

        // only ch3 and ch12, then ch12 drops
        vld16 = 16'h1008;
        for (int i = 0; i < 4; i++) begin rnd_data(); cyc(); end
        vld16 = 16'h0008;
        for (int i = 0; i < 3; i++) begin rnd_data(); cyc(); end

        // manual sel out of range on the 5-channel instance
        mode = 1'b0; sel5 = 3'd6; vld5 = '1;
        for (int i = 0; i < 3; i++) begin rnd_data(); cyc(); end

        // reset while holding a word with rr_ptr = 7
        mode = 1'b1; vld16 = '1; vld5 = '1;
        for (int i = 0; i < 20 && m_ptr[0] != 7; i++) begin rnd_data(); cyc(); end
        chk("ptr_reached_7", 32'(m_ptr[0]), 32'd7);
        rst_n = 1'b0;
        cyc();
        chk("rst_out_valid", 32'(ov16), 32'd0);
        chk("rst_out_data", 32'(od16), 32'd0);
        chk("rst_out_ch", 32'(ch16), 32'd0);
        rst_n = 1'b1;
        rnd_data();
        cyc();
        chk("post_rst_gnt", 32'(ch16), 32'd0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            rnd_data();
            mode      = 1'($urandom);
            sel16     = 4'($urandom);
            sel5      = 3'($urandom);
            vld16     = 16'($urandom & $urandom);
            vld5      = 5'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            rst_n     = ($urandom_range(0, 49) != 0);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
